// File: rtl/tdm_pkg.sv
// Shared definitions for the 1:8 TDM receive path.
//   NUM_CH  : number of channels in one frame
//   CH_W    : width of a channel index
//   state_t : framing state (HUNT waits for a sync, LOCKED tracks the frame)
package tdm_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux8_decoder3_8.sv
// decoder3_8: combinational 3-to-8 one-hot write-enable decoder.
// This is the structural inverse of the 8:1 mux select: the mux picks one
// input by index, and this block raises one shadow-slot enable by index.
//   sel    : slot index
//   en     : overall write qualifier; no bit is set when low
//   onehot : one-hot write enables, bit k selects slot k
module decoder3_8
  import tdm_pkg::*;
(
  input  logic [CH_W-1:0]   sel,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: sequential 1:8 time-division demultiplexer.
// Samples arriving on x are steered into an eight-slot shadow bank indexed by
// a channel counter. When the channel-7 sample arrives the whole frame is
// published on y0..y7 in the same edge and frame_valid pulses for one cycle.
// A frame must start with sync on channel 0; framing violations pulse
// sync_err and either restart the frame (early sync) or drop lock (missing
// sync).
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   x           : serial sample stream
//   x_valid     : x carries a sample this cycle
//   sync        : (with x_valid) marks the sample as channel 0
//   y0..y7      : registered frame outputs
//   frame_valid : one-cycle pulse when y0..y7 take a new frame
//   ch          : channel the next valid sample will be written to
//   locked      : high while in LOCKED
//   sync_err    : one-cycle pulse on a framing error
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic             x_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic             frame_valid,
  output logic [CH_W-1:0]  ch,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   cnt, cnt_nxt;
  logic              shadow_wr;
  logic              frame_done;
  logic              err_nxt;
  logic [CH_W-1:0]   wr_sel;
  logic [NUM_CH-1:0] wr_en;

  logic [WIDTH-1:0]  shadow [NUM_CH];
  logic [WIDTH-1:0]  y_q    [NUM_CH];

  // Next-state, counter and event decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_wr  = 1'b0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    if (x_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            shadow_wr = 1'b1;
            cnt_nxt   = CH_W'(1);
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Channel 0 in the right place, or an early sync restarting the frame.
            shadow_wr = 1'b1;
            err_nxt   = (cnt != '0);
            cnt_nxt   = CH_W'(1);
          end else if (cnt == '0) begin
            // A frame must open with sync; without it lock is lost.
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end else begin
            shadow_wr = 1'b1;
            if (cnt == LAST_CH) begin
              frame_done = 1'b1;
              cnt_nxt    = '0;
            end else begin
              cnt_nxt = cnt + CH_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // A sync sample always lands in slot 0, whatever the counter says.
  assign wr_sel = sync ? '0 : cnt;

  decoder3_8 u_dec (
    .sel    (wr_sel),
    .en     (shadow_wr),
    .onehot (wr_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_valid <= frame_done;
      sync_err    <= err_nxt;
    end
  end

  // Shadow bank and published frame. The channel-7 sample bypasses the
  // shadow so the frame is complete in the same edge that accepts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i]) shadow[i] <= x;
      end
      if (frame_done) begin
        for (int i = 0; i < NUM_CH - 1; i++) y_q[i] <= shadow[i];
        y_q[NUM_CH-1] <= x;
      end
    end
  end

  assign y0     = y_q[0];
  assign y1     = y_q[1];
  assign y2     = y_q[2];
  assign y3     = y_q[3];
  assign y4     = y_q[4];
  assign y5     = y_q[5];
  assign y6     = y_q[6];
  assign y7     = y_q[7];
  assign ch     = cnt;
  assign locked = (state == LOCKED);

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Sequential 1:8 time-division demultiplexer, the receive-side counterpart of the 8:1 channel multiplexer.
- Accepts one serial sample stream with a frame-sync marker on channel 0.
- Steers each sample into one of eight channel slots and publishes a complete frame on eight parallel outputs.
- Channel k maps to mux input xk, with k = {s0,s1,s2} and s0 as MSB.

Parameters:
- WIDTH, 1, bit width of each sample and of each output channel.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- x  input  WIDTH  serial sample stream
- x_valid  input  1  sample on x is valid this cycle
- sync  input  1  qualified by x_valid; marks the current sample as channel 0
- y0..y7  output  WIDTH each  registered frame outputs, one per channel
- frame_valid  output  1  one-cycle pulse when y0..y7 update with a new frame
- ch  output  3  channel index the next valid sample will be written to
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on a framing error

Behaviour:
- Reset: while rst_n=0 at a clk edge:
  - state=HUNT, cnt=0.
  - y0..y7=0, shadow bank=0.
  - frame_valid=0, sync_err=0, locked=0, ch=0.
  - Reset mid-frame discards the partial frame. No frame_valid is produced for it.
- Cycles with x_valid=0: no state change; all registers hold. sync is ignored.
- State HUNT:
  - x_valid=1, sync=0: sample is discarded; stay in HUNT.
  - x_valid=1, sync=1: shadow[0]<=x, cnt<=1, go to LOCKED.
- State LOCKED, on x_valid=1:
  - cnt!=0, sync=0: shadow[cnt]<=x.
    - If cnt==7: y0..y6<=shadow[0..6] and y7<=x in the same edge; frame_valid=1 for the following cycle; cnt<=0.
    - Otherwise cnt<=cnt+1.
  - cnt==0, sync=1: normal channel 0. shadow[0]<=x, cnt<=1.
  - cnt!=0, sync=1 (early sync):
    - sync_err pulse; partial frame discarded, no frame_valid.
    - shadow[0]<=x, cnt<=1; stay in LOCKED.
  - cnt==0, sync=0 (missing sync):
    - sync_err pulse; sample discarded.
    - cnt stays 0; go to HUNT.
- Latency: y0..y7 and frame_valid change at the same edge that accepts the channel-7 sample, so they are visible one cycle after that sample is presented. y0..y7 hold until the next complete frame.
- Pulse widths: frame_valid and sync_err are single-cycle pulses and are never high simultaneously.
- Back-to-back frames: a channel-0 sample (with sync) may arrive in the cycle immediately after the channel-7 sample; no bubble is required.
- ch = cnt. locked = (state==LOCKED).
- Wrap-around: cnt is 3-bit and wraps 7->0 only through the cnt==7 frame-complete path.

Decomposition:
- Shared package tdm_pkg holds:
  - NUM_CH=8, CH_W=3.
  - State enum {HUNT, LOCKED}.
- One natural sub-module: decoder3_8, a combinational 3-to-8 one-hot write-enable decoder driven by cnt and gated by the shadow write condition. It is the structural inverse of the mux select logic.
- Shadow bank, counter and FSM stay in tdm_demux8.

Test Plan:
1. Reset and lock, WIDTH=1:
   - Stimulus: rst_n low 2 cycles, release; then 8 valid samples 1,0,1,1,0,0,1,0 with sync on the first.
   - Required: all outputs 0 during reset; locked=1 after the first sample; one cycle after sample 8, frame_valid=1 and y0..y7=1,0,1,1,0,0,1,0.
2. Gapped input, WIDTH=8:
   - Stimulus: frame 0x10..0x17 with x_valid low for 3 cycles between every sample.
   - Required: ch steps 0..7 only on valid cycles; single frame_valid; y0=0x10 .. y7=0x17.
3. Back-to-back frames:
   - Stimulus: two frames sent consecutively with no idle cycles, values 0xA0..0xA7 then 0xB0..0xB7.
   - Required: exactly two frame_valid pulses, 8 cycles apart; y holds the 0xAx values between the pulses.
4. Early sync:
   - Stimulus: sync asserted on the 5th sample of a frame.
   - Required: sync_err pulses one cycle; no frame_valid for the partial frame; that sample lands in y0 of the next completed frame; locked stays 1.
5. Missing sync:
   - Stimulus: after a complete frame, the next valid sample has sync=0.
   - Required: sync_err pulse; locked=0; further samples ignored until sync; y retains the previous frame.
6. Reset mid-frame:
   - Stimulus: rst_n low after 4 samples of a frame.
   - Required: y0..y7=0, ch=0, locked=0; no frame_valid until a new full frame is received.
